// File: rtl/hazard_pipe_tracker_if.sv
// Decode-side capture inputs and E/M/W stage outputs of the pipeline stage
// tracker. The master drives the decode fields and controls. The slave is
// the tracker itself.
interface hazard_pipe_tracker_if #(
    parameter int unsigned CNT_W = 32
);
    // Pipeline control
    logic             freeze;
    logic             stall;
    logic             clr_cnt;

    // Decode-stage instruction fields
    logic             D_valid;
    logic [4:0]       D_GRF_RA1;
    logic [4:0]       D_GRF_RA2;
    logic [4:0]       D_GRF_WA;
    logic             D_WE;
    logic [1:0]       D_Tnew;

    // Execute stage
    logic [4:0]       E_GRF_RA1;
    logic [4:0]       E_GRF_RA2;
    logic [4:0]       E_GRF_WA;
    logic             E_WE;
    logic [1:0]       Tnew_E;

    // Memory stage
    logic [4:0]       M_GRF_RA2;
    logic [4:0]       M_GRF_WA;
    logic             M_WE;
    logic [1:0]       Tnew_M;

    // Writeback stage
    logic [4:0]       W_GRF_WA;
    logic             W_WE;
    logic [1:0]       Tnew_W;

    // Stall-cycle performance counter
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output freeze, stall, clr_cnt,
        output D_valid, D_GRF_RA1, D_GRF_RA2, D_GRF_WA, D_WE, D_Tnew,
        input  E_GRF_RA1, E_GRF_RA2, E_GRF_WA, E_WE, Tnew_E,
        input  M_GRF_RA2, M_GRF_WA, M_WE, Tnew_M,
        input  W_GRF_WA, W_WE, Tnew_W,
        input  stall_cycles
    );

    modport slave (
        input  freeze, stall, clr_cnt,
        input  D_valid, D_GRF_RA1, D_GRF_RA2, D_GRF_WA, D_WE, D_Tnew,
        output E_GRF_RA1, E_GRF_RA2, E_GRF_WA, E_WE, Tnew_E,
        output M_GRF_RA2, M_GRF_WA, M_WE, Tnew_M,
        output W_GRF_WA, W_WE, Tnew_W,
        output stall_cycles
    );
endinterface

// File: rtl/hazard_pipe_tracker.sv
// Stage-tracking register bank for the 5-stage pipeline. Captures the
// register addresses, write enable and Tnew of each instruction at decode.
// These fields then shift through E, M and W. A stall inserts a bubble into
// E and a freeze holds every stage. Tnew counts down on each advance. A
// saturating counter records the number of unfrozen stall cycles.
module hazard_pipe_tracker #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_pipe_tracker_if.slave  bus
);

    // Stage register state
    logic [4:0]       e_ra1_q, e_ra1_d;
    logic [4:0]       e_ra2_q, e_ra2_d;
    logic [4:0]       e_wa_q,  e_wa_d;
    logic             e_we_q,  e_we_d;
    logic [1:0]       e_tnew_q, e_tnew_d;

    logic [4:0]       m_ra2_q, m_ra2_d;
    logic [4:0]       m_wa_q,  m_wa_d;
    logic             m_we_q,  m_we_d;
    logic [1:0]       m_tnew_q, m_tnew_d;

    logic [4:0]       w_wa_q,  w_wa_d;
    logic             w_we_q,  w_we_d;
    logic [1:0]       w_tnew_q, w_tnew_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decode-side capture values
    logic             d_we_eff;
    logic [1:0]       d_tnew_clamped;
    logic             e_bubble;

    // Saturating decrement. Tnew never wraps below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Effective write enable and clamped Tnew for the instruction in decode
    always_comb begin
        d_we_eff       = bus.D_WE & bus.D_valid & (bus.D_GRF_WA != 5'd0);
        d_tnew_clamped = (bus.D_Tnew == 2'd3) ? 2'd2 : bus.D_Tnew;
        e_bubble       = bus.stall | ~bus.D_valid;
    end

    // Next-state of the E/M/W stages: hold on freeze, otherwise advance
    always_comb begin
        e_ra1_d  = e_ra1_q;
        e_ra2_d  = e_ra2_q;
        e_wa_d   = e_wa_q;
        e_we_d   = e_we_q;
        e_tnew_d = e_tnew_q;
        m_ra2_d  = m_ra2_q;
        m_wa_d   = m_wa_q;
        m_we_d   = m_we_q;
        m_tnew_d = m_tnew_q;
        w_wa_d   = w_wa_q;
        w_we_d   = w_we_q;
        w_tnew_d = w_tnew_q;

        if (!bus.freeze) begin
            // A stalled or invalid decode slot enters E as an all-zero bubble
            if (e_bubble) begin
                e_ra1_d  = '0;
                e_ra2_d  = '0;
                e_wa_d   = '0;
                e_we_d   = 1'b0;
                e_tnew_d = '0;
            end else begin
                e_ra1_d  = bus.D_GRF_RA1;
                e_ra2_d  = bus.D_GRF_RA2;
                e_wa_d   = bus.D_GRF_WA;
                e_we_d   = d_we_eff;
                e_tnew_d = d_we_eff ? d_tnew_clamped : 2'd0;
            end

            m_ra2_d  = e_ra2_q;
            m_wa_d   = e_wa_q;
            m_we_d   = e_we_q;
            m_tnew_d = tnew_dec(e_tnew_q);

            w_wa_d   = m_wa_q;
            w_we_d   = m_we_q;
            w_tnew_d = tnew_dec(m_tnew_q);
        end
    end

    // Next-state of the stall counter. Clear beats freeze and increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (!bus.freeze && bus.stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ra1_q  <= '0;
            e_ra2_q  <= '0;
            e_wa_q   <= '0;
            e_we_q   <= 1'b0;
            e_tnew_q <= '0;
            m_ra2_q  <= '0;
            m_wa_q   <= '0;
            m_we_q   <= 1'b0;
            m_tnew_q <= '0;
            w_wa_q   <= '0;
            w_we_q   <= 1'b0;
            w_tnew_q <= '0;
            cnt_q    <= '0;
        end else begin
            e_ra1_q  <= e_ra1_d;
            e_ra2_q  <= e_ra2_d;
            e_wa_q   <= e_wa_d;
            e_we_q   <= e_we_d;
            e_tnew_q <= e_tnew_d;
            m_ra2_q  <= m_ra2_d;
            m_wa_q   <= m_wa_d;
            m_we_q   <= m_we_d;
            m_tnew_q <= m_tnew_d;
            w_wa_q   <= w_wa_d;
            w_we_q   <= w_we_d;
            w_tnew_q <= w_tnew_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.E_GRF_RA1    = e_ra1_q;
    assign bus.E_GRF_RA2    = e_ra2_q;
    assign bus.E_GRF_WA     = e_wa_q;
    assign bus.E_WE         = e_we_q;
    assign bus.Tnew_E       = e_tnew_q;
    assign bus.M_GRF_RA2    = m_ra2_q;
    assign bus.M_GRF_WA     = m_wa_q;
    assign bus.M_WE         = m_we_q;
    assign bus.Tnew_M       = m_tnew_q;
    assign bus.W_GRF_WA     = w_wa_q;
    assign bus.W_WE         = w_we_q;
    assign bus.Tnew_W       = w_tnew_q;
    assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Self-checking bench for hazard_pipe_tracker. A behavioural model keeps each
// stage's instruction together with the Tnew it was captured with. The model
// derives the stage Tnew from how far the instruction has advanced. Directed
// scenarios pin the model with literal values. A randomized phase then runs
// against the same model.
module tb_hazard_pipe_tracker;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    hazard_pipe_tracker_if #(.CNT_W(CNT_W)) bus ();

    hazard_pipe_tracker #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int ra1;
        int ra2;
        int wa;
        int we;
        int tn;   // Tnew as captured in decode
    } ent_t;

    ent_t mE = '{0, 0, 0, 0, 0};
    ent_t mM = '{0, 0, 0, 0, 0};
    ent_t mW = '{0, 0, 0, 0, 0};
    int   mcnt = 0;

    function automatic ent_t bubble();
        ent_t b = '{0, 0, 0, 0, 0};
        return b;
    endfunction

    // Tnew seen by an instruction that has advanced 'age' stages past E
    function automatic int tnew_at(input int tn, input int age);
        return (tn > age) ? tn - age : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mE = bubble(); mM = bubble(); mW = bubble(); mcnt = 0;
        end else begin
            if (bus.clr_cnt) mcnt = 0;
            else if (!bus.freeze && bus.stall && mcnt < CNT_MAX) mcnt = mcnt + 1;
            if (!bus.freeze) begin
                mW = mM;
                mM = mE;
                if (bus.stall || !bus.D_valid) begin
                    mE = bubble();
                end else begin
                    mE.ra1 = int'(bus.D_GRF_RA1);
                    mE.ra2 = int'(bus.D_GRF_RA2);
                    mE.wa  = int'(bus.D_GRF_WA);
                    mE.we  = (bus.D_WE && bus.D_GRF_WA != 5'd0) ? 1 : 0;
                    mE.tn  = mE.we ? ((int'(bus.D_Tnew) > 2) ? 2 : int'(bus.D_Tnew)) : 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("E_RA1", int'(bus.E_GRF_RA1), mE.ra1);
        chk("E_RA2", int'(bus.E_GRF_RA2), mE.ra2);
        chk("E_WA",  int'(bus.E_GRF_WA),  mE.wa);
        chk("E_WE",  int'(bus.E_WE),      mE.we);
        chk("Tnew_E", int'(bus.Tnew_E),   tnew_at(mE.tn, 0));
        chk("M_RA2", int'(bus.M_GRF_RA2), mM.ra2);
        chk("M_WA",  int'(bus.M_GRF_WA),  mM.wa);
        chk("M_WE",  int'(bus.M_WE),      mM.we);
        chk("Tnew_M", int'(bus.Tnew_M),   tnew_at(mM.tn, 1));
        chk("W_WA",  int'(bus.W_GRF_WA),  mW.wa);
        chk("W_WE",  int'(bus.W_WE),      mW.we);
        chk("Tnew_W", int'(bus.Tnew_W),   tnew_at(mW.tn, 2));
        chk("stall_cycles", int'(bus.stall_cycles), mcnt);
    end

    // ---------------- stimulus ----------------
    task automatic drive_d(input int v, input int ra1, input int ra2,
                           input int wa, input int we, input int tn);
        bus.D_valid   = v[0];
        bus.D_GRF_RA1 = ra1[4:0];
        bus.D_GRF_RA2 = ra2[4:0];
        bus.D_GRF_WA  = wa[4:0];
        bus.D_WE      = we[0];
        bus.D_Tnew    = tn[1:0];
    endtask

    // Advance one edge and land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.freeze  = 1'b0;
        bus.stall   = 1'b0;
        bus.clr_cnt = 1'b0;
        drive_d(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("reset E_WE", int'(bus.E_WE), 0);
        chk("reset stall_cycles", int'(bus.stall_cycles), 0);

        // Load propagation through E, M, W
        drive_d(1, 7, 9, 8, 1, 2);
        tick();
        chk("load E_WA", int'(bus.E_GRF_WA), 8);
        chk("load Tnew_E", int'(bus.Tnew_E), 2);
        drive_d(0, 0, 0, 0, 0, 0);
        tick();
        chk("load M_WA", int'(bus.M_GRF_WA), 8);
        chk("load Tnew_M", int'(bus.Tnew_M), 1);
        chk("load M_RA2", int'(bus.M_GRF_RA2), 9);
        tick();
        chk("load W_WA", int'(bus.W_GRF_WA), 8);
        chk("load Tnew_W", int'(bus.Tnew_W), 0);
        chk("load W_WE", int'(bus.W_WE), 1);

        // Asynchronous reset with a load sitting in M
        drive_d(1, 7, 9, 8, 1, 2);
        tick();
        drive_d(0, 0, 0, 0, 0, 0);
        tick();
        chk("pre-reset M_WA", int'(bus.M_GRF_WA), 8);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset M_WA", int'(bus.M_GRF_WA), 0);
        chk("async reset M_WE", int'(bus.M_WE), 0);
        chk("async reset Tnew_M", int'(bus.Tnew_M), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single stall delays the ALU op by one cycle
        drive_d(1, 1, 2, 3, 1, 1);
        bus.stall = 1'b1;
        tick();
        chk("stall E_WE", int'(bus.E_WE), 0);
        chk("stall E_WA", int'(bus.E_GRF_WA), 0);
        chk("stall count", int'(bus.stall_cycles), 1);
        bus.stall = 1'b0;
        tick();
        chk("after stall E_WA", int'(bus.E_GRF_WA), 3);
        chk("after stall Tnew_E", int'(bus.Tnew_E), 1);

        // Freeze dominates stall
        drive_d(1, 4, 4, 5, 1, 2);
        bus.freeze = 1'b1;
        bus.stall  = 1'b1;
        repeat (3) tick();
        chk("freeze E_WA", int'(bus.E_GRF_WA), 3);
        chk("freeze M_WA", int'(bus.M_GRF_WA), 0);
        chk("freeze count", int'(bus.stall_cycles), 1);
        bus.freeze = 1'b0;
        repeat (2) tick();
        chk("2 stalls E_WE", int'(bus.E_WE), 0);
        chk("2 stalls W_WA", int'(bus.W_GRF_WA), 3);
        chk("2 stalls count", int'(bus.stall_cycles), 3);
        bus.stall = 1'b0;

        // Write to $0 is not advertised; invalid decode becomes a bubble
        drive_d(1, 4, 6, 0, 1, 1);
        tick();
        chk("$0 E_WE", int'(bus.E_WE), 0);
        chk("$0 Tnew_E", int'(bus.Tnew_E), 0);
        chk("$0 E_RA1", int'(bus.E_GRF_RA1), 4);
        drive_d(0, 6, 6, 5, 1, 2);
        tick();
        chk("invalid E_WA", int'(bus.E_GRF_WA), 0);
        chk("invalid E_RA1", int'(bus.E_GRF_RA1), 0);

        // Illegal Tnew encoding is clamped
        drive_d(1, 1, 1, 10, 1, 3);
        tick();
        chk("clamp Tnew_E", int'(bus.Tnew_E), 2);

        // Counter saturation, then clear while still stalling
        bus.stall = 1'b1;
        repeat (20) tick();
        chk("saturated count", int'(bus.stall_cycles), 15);
        bus.clr_cnt = 1'b1;
        tick();
        chk("cleared count", int'(bus.stall_cycles), 0);
        bus.clr_cnt = 1'b0;
        bus.stall   = 1'b0;

        // Randomized phase against the model
        for (int i = 0; i < 3000; i++) begin
            bus.freeze  = ($urandom_range(0, 99) < 15);
            bus.stall   = ($urandom_range(0, 99) < 30);
            bus.clr_cnt = ($urandom_range(0, 99) < 4);
            drive_d(($urandom_range(0, 99) < 85) ? 1 : 0,
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
